// File: rtl/rfid_pkg.sv
// Shared types for the RFID frame decoder: FSM states, run units,
// the quantizer-to-decoder bundle and the Wiegand parity helper.
package rfid_pkg;

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] DATA_A = 2'd1;
  localparam logic [1:0] DATA_B = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [7:0] HID_PREAMBLE = 8'b0001_1101;
  localparam int         WIEGAND_BITS = 26;

  typedef enum logic [2:0] {
    U_GLITCH = 3'd0,
    U_ONE    = 3'd1,
    U_TWO    = 3'd2,
    U_THREE  = 3'd3,
    U_LONG   = 3'd4
  } unit_e;

  typedef struct packed {
    logic  stb;
    unit_e unit;
    logic  level;
    logic  sat;
  } run_t;

  // Bit 25 even over 24..13, bit 0 odd over 12..1.
  function automatic logic wiegand_ok(input logic [WIEGAND_BITS-1:0] w);
    return (w[25] == ^w[24:13]) && (w[0] == ~^w[12:1]);
  endfunction

endpackage

// File: rtl/run_quantizer.sv
// Synchronizes fsk_bit, measures run lengths in clk cycles and
// classifies each completed run into half-bit units.
import rfid_pkg::*;

module run_quantizer #(
  parameter int HALF_BIT = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fsk_bit,
  output run_t run
);

  localparam int CW = $clog2(4 * HALF_BIT + 1);
  localparam logic [CW-1:0] SAT  = CW'(4 * HALF_BIT);
  localparam logic [CW-1:0] LIM1 = CW'(HALF_BIT / 2);
  localparam logic [CW-1:0] LIM2 = CW'((3 * HALF_BIT) / 2);
  localparam logic [CW-1:0] LIM3 = CW'((5 * HALF_BIT) / 2);
  localparam logic [CW-1:0] LIM4 = CW'((7 * HALF_BIT) / 2);

  logic          s1, s2, s_prev;
  logic          edge_d;
  logic [CW-1:0] cnt;
  unit_e         unit_d;
  logic          stb_q;
  unit_e         unit_q;
  logic          level_q;

  assign edge_d = s2 ^ s_prev;

  always_comb begin
    unit_d = U_LONG;
    if (cnt < LIM1)      unit_d = U_GLITCH;
    else if (cnt < LIM2) unit_d = U_ONE;
    else if (cnt < LIM3) unit_d = U_TWO;
    else if (cnt < LIM4) unit_d = U_THREE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s_prev  <= 1'b0;
      cnt     <= '0;
      stb_q   <= 1'b0;
      unit_q  <= U_GLITCH;
      level_q <= 1'b0;
    end else begin
      s1     <= fsk_bit;
      s2     <= s1;
      s_prev <= s2;
      stb_q  <= edge_d;
      if (edge_d) begin
        unit_q  <= unit_d;
        level_q <= s_prev;
        cnt     <= CW'(1);
      end else if (cnt != SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Raised one cycle early so a registered abort lands as cnt hits SAT.
  assign run = '{
    stb:   stb_q,
    unit:  unit_q,
    level: level_q,
    sat:   !edge_d && (cnt == SAT - 1'b1)
  };

endmodule

// File: rtl/rfid_frame_decoder.sv
// HID preamble lock, Manchester pair decode and tag ID assembly.
// Define FRAME_PARITY_EN to reject frames failing Wiegand parity.
import rfid_pkg::*;

module rfid_frame_decoder #(
  parameter int HALF_BIT = 10000,
  parameter int ID_BITS  = 44
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fsk_bit,
  output logic [ID_BITS-1:0] id_data,
  output logic               id_valid,
  output logic               frame_err,
  output logic               parity_err
);

  localparam int BW = $clog2(ID_BITS + 1);

  run_t               run;
  logic [1:0]         rem;
  logic               sym_level;
  logic               emit_ok;
  logic               sym_vld;
  logic               sym;
  logic [1:0]         state;
  logic [7:0]         sym_sr;
  logic [7:0]         sr_nx;
  logic [3:0]         fill;
  logic [3:0]         fill_nx;
  logic               first_half;
  logic [ID_BITS-1:0] id_sr;
  logic [BW-1:0]      bit_cnt;
  logic               in_data;
  logic               bad_unit;
  logic               hunt_clr;
  logic               pair_bad;
  logic               abort;

  run_quantizer #(.HALF_BIT(HALF_BIT)) u_quant (
    .clk     (clk),
    .rst_n   (rst_n),
    .fsk_bit (fsk_bit),
    .run     (run)
  );

  assign emit_ok = run.stb &&
    (run.unit == U_ONE || run.unit == U_TWO || run.unit == U_THREE);
  assign sym_vld = emit_ok || (rem != 2'd0);
  assign sym     = run.stb ? run.level : sym_level;

  assign sr_nx   = {sym_sr[6:0], sym};
  assign fill_nx = (fill == 4'd8) ? 4'd8 : fill + 4'd1;

  assign in_data  = (state == DATA_A) || (state == DATA_B);
  assign hunt_clr = run.stb &&
    (run.unit == U_GLITCH || run.unit == U_LONG);
  assign bad_unit = hunt_clr || (run.stb && run.unit == U_THREE);
  assign pair_bad = (state == DATA_B) && sym_vld && (sym == first_half);
  assign abort    = (in_data && (bad_unit || run.sat)) || pair_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= 2'd0;
      sym_level <= 1'b0;
    end else if (abort) begin
      rem <= 2'd0;
    end else if (emit_ok) begin
      rem       <= 2'(run.unit) - 2'd1;
      sym_level <= run.level;
    end else if (rem != 2'd0) begin
      rem <= rem - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      sym_sr     <= '0;
      fill       <= '0;
      first_half <= 1'b0;
      id_sr      <= '0;
      bit_cnt    <= '0;
      id_data    <= '0;
      id_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef FRAME_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      id_valid  <= 1'b0;
      frame_err <= abort;
`ifdef FRAME_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        HUNT: begin
          if (hunt_clr) begin
            fill <= '0;
          end else if (sym_vld) begin
            sym_sr <= sr_nx;
            if (fill_nx == 4'd8 && sr_nx == HID_PREAMBLE) begin
              state   <= DATA_A;
              fill    <= '0;
              bit_cnt <= '0;
            end else begin
              fill <= fill_nx;
            end
          end
        end
        DATA_A: begin
          if (abort) begin
            state <= HUNT;
          end else if (sym_vld) begin
            first_half <= sym;
            state      <= DATA_B;
          end
        end
        DATA_B: begin
          if (abort) begin
            state <= HUNT;
          end else if (sym_vld) begin
            id_sr   <= {id_sr[ID_BITS-2:0], first_half};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= (bit_cnt == BW'(ID_BITS - 1)) ? DONE : DATA_A;
          end
        end
        DONE: begin
          state <= HUNT;
          fill  <= '0;
`ifdef FRAME_PARITY_EN
          if (wiegand_ok(id_sr[WIEGAND_BITS-1:0])) begin
            id_data  <= id_sr;
            id_valid <= 1'b1;
          end else begin
            parity_err <= 1'b1;
          end
`else
          id_data  <= id_sr;
          id_valid <= 1'b1;
`endif
        end
      endcase
    end
  end

`ifndef FRAME_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rfid_frame_decoder.sv
// Scoreboard bench for rfid_frame_decoder with a waveform-level
// reference that builds each frame as a list of timed runs.
`timescale 1ns/1ps

module tb_rfid_frame_decoder;

  localparam int H  = 20;
  localparam int NB = 44;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fsk_bit;
  logic [NB-1:0] id_data;
  logic          id_valid;
  logic          frame_err;
  logic          parity_err;

  rfid_frame_decoder #(.HALF_BIT(H), .ID_BITS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fsk_bit    (fsk_bit),
    .id_data    (id_data),
    .id_valid   (id_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef enum {EV_VALID, EV_FERR, EV_PERR} ev_e;
  typedef struct {
    ev_e           kind;
    logic [NB-1:0] id;
  } ev_t;

  ev_t           expq[$];
  int            total = 0;
  int            bad   = 0;
  logic [NB-1:0] model_id;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] kind_bits(input ev_e k);
    case (k)
      EV_VALID: return 3'b100;
      EV_FERR:  return 3'b010;
      default:  return 3'b001;
    endcase
  endfunction

  function automatic bit parity_ok(input logic [NB-1:0] id);
    int ev = 0;
    int od = 0;
    bit ok;
    bit en;
    for (int i = 13; i <= 25; i++) ev += int'(id[i]);
    for (int i = 0; i <= 12; i++) od += int'(id[i]);
    ok = (ev % 2 == 0) && (od % 2 == 1);
`ifdef FRAME_PARITY_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return ok || !en;
  endfunction

  function automatic logic [NB-1:0] fix_parity(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    int ev = 0;
    int od = 0;
    r = v;
    for (int i = 13; i <= 24; i++) ev += int'(r[i]);
    for (int i = 1; i <= 12; i++) od += int'(r[i]);
    r[25] = ev[0];
    r[0]  = ~od[0];
    return r;
  endfunction

  function automatic int jit(input int mode);
    case (mode)
      1:       return (2 * H) / 5;
      2:       return -(2 * H) / 5;
      3:       return int'($urandom_range(0, 14)) - 7;
      default: return 0;
    endcase
  endfunction

  task automatic hold(input bit lvl, input int cyc);
    fsk_bit = lvl;
    repeat (cyc) @(negedge clk);
  endtask

  // mode: 0 exact, 1 +40%, 2 -40%, 3 random jitter; stop>=0 truncates.
  task automatic send_frame(input logic [NB-1:0] id, input int mode,
                            input bit bad_frame, input int stop);
    logic [7:0] pre;
    bit         syms[$];
    int         lens[$];
    bit         lvls[$];
    int         bad_run;
    int         dur;
    ev_t        e;
    pre = 8'b0001_1101;
    for (int i = 7; i >= 0; i--) syms.push_back(pre[i]);
    for (int i = NB - 1; i >= 0; i--) begin
      syms.push_back(id[i]);
      syms.push_back(!id[i]);
    end
    for (int i = 0; i < syms.size(); i++) begin
      if (i > 0 && syms[i] == syms[i-1]) begin
        lens[lens.size()-1] += 1;
      end else begin
        lens.push_back(1);
        lvls.push_back(syms[i]);
      end
    end
    bad_run = bad_frame ? lens.size() / 2 : -1;
    if (stop < 0) begin
      if (bad_frame) begin
        e = '{EV_FERR, model_id};
      end else if (parity_ok(id)) begin
        model_id = id;
        e = '{EV_VALID, id};
      end else begin
        e = '{EV_PERR, model_id};
      end
      expq.push_back(e);
    end
    hold(1'b1, 5 * H + jit(mode));
    for (int r = 0; r < lens.size(); r++) begin
      if (r == stop) return;
      dur = (r == bad_run) ? 3 * H : lens[r] * H + jit(mode);
      hold(lvls[r], dur);
    end
    hold(!lvls[lvls.size()-1], 2 * H + jit(mode));
  endtask

  initial begin
    logic [NB-1:0] last_id;
    logic [2:0]    flags;
    ev_t           e;
    last_id = '0;
    forever begin
      @(negedge clk);
      flags = {id_valid, frame_err, parity_err};
      if (!rst_n) begin
        last_id = '0;
      end else if (flags != 3'b000) begin
        check("exclusive", 64'(int'(id_valid) + int'(frame_err) +
              int'(parity_err)), 64'd1);
        if (expq.size() == 0) begin
          check("unexpected_event", 64'(flags), 64'd0);
        end else begin
          e = expq.pop_front();
          check("event_kind", 64'(flags), 64'(kind_bits(e.kind)));
          check("event_id", 64'(id_data), 64'(e.id));
          last_id = e.id;
        end
      end else begin
        check("id_hold", 64'(id_data), 64'(last_id));
        if (id_data !== last_id) last_id = id_data;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NB-1:0] gold;
    logic [NB-1:0] rid;
    int            n;
    gold     = 44'h0A5_5A5A_5A5A;
    model_id = '0;
    rst_n    = 1'b0;
    fsk_bit  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_id_data", 64'(id_data), 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_parity_err", 64'(parity_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(gold, 0, 1'b0, -1);
    send_frame(gold, 1, 1'b0, -1);
    send_frame(gold, 2, 1'b0, -1);
    send_frame(gold, 0, 1'b1, -1);
    send_frame(gold, 0, 1'b0, -1);

    expq.push_back('{EV_FERR, model_id});
    hold(1'b1, 5 * H);
    hold(1'b0, 3 * H);
    hold(1'b1, 3 * H);
    hold(1'b0, H);
    hold(1'b1, H);
    fsk_bit = 1'b0;
    n = 0;
    while (n < 5 * H && !frame_err) begin
      @(negedge clk);
      n++;
    end
    check("sat_latency", 64'(n), 64'(4 * H + 2));
    repeat (5 * H - n) @(negedge clk);

    rid = gold ^ 44'd1;
    send_frame(rid, 0, 1'b0, -1);

    for (int k = 0; k < 8; k++) begin
      rid = NB'({$urandom(), $urandom()});
      if (k % 2 == 1) rid = fix_parity(rid);
      send_frame(rid, 3, 1'b0, -1);
    end

    send_frame(gold ^ 44'hFF, 0, 1'b0, 40);
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fsk_bit = ~fsk_bit;
      @(negedge clk);
    end
    check("midrst_id_data", 64'(id_data), 64'd0);
    check("midrst_id_valid", 64'(id_valid), 64'd0);
    check("midrst_frame_err", 64'(frame_err), 64'd0);
    check("midrst_parity_err", 64'(parity_err), 64'd0);
    model_id = '0;
    rst_n = 1'b1;
    send_frame(gold, 0, 1'b0, -1);

    repeat (10 * H) @(negedge clk);
    check("queue_empty", 64'(expq.size()), 64'd0);
    check("final_id", 64'(id_data), 64'(model_id));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
